// File: rtl/tmc_timer_sequencer_if.sv
// Bus bundle between the timer sequencer and the 16-bit interval timer s1 slave.
// The sequencer is the master: it drives address/chipselect/write strobe/data
// and receives the timer interrupt.
//   tmr_address    3   register select (0 status, 1 control, 2 period_l, 3 period_h)
//   tmr_chipselect 1   slave select
//   tmr_write_n    1   write strobe, active low
//   tmr_writedata  16  write data
//   tmr_irq        1   timer interrupt (timeout_occurred AND ITO)
interface tmc_timer_sequencer_if;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        tmr_irq;

  modport master (
    output tmr_address,
    output tmr_chipselect,
    output tmr_write_n,
    output tmr_writedata,
    input  tmr_irq
  );

  modport slave (
    input  tmr_address,
    input  tmr_chipselect,
    input  tmr_write_n,
    input  tmr_writedata,
    output tmr_irq
  );
endinterface

// File: rtl/tmc_timer_sequencer.sv
// Shares one 16-bit interval timer among NUM_REQ timeout requesters.
// A round-robin arbiter grants one requester, the block programs the timer
// period (low, high), lets the timer settle, starts a one-shot timeout, then
// waits for the irq or for the owner to withdraw its request. It stops the
// timer on cancel, clears the timeout status and pulses done to the owner.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   req           level requests, held until the matching done pulse
//   req_period    32-bit period per requester, requester k at [32k+31:32k]
//   done          one-cycle completion pulse to the owner
//   aborted       qualifies done: 1 = cancelled, 0 = timed out
//   busy          high from grant through the done cycle
//   owner         index of the current owner while busy
//   tmr           timer s1 master bus (writes only, irq input)
module tmc_timer_sequencer #(
  parameter int NUM_REQ    = 4,
  parameter int OWNER_W    = 2,
  parameter int MIN_PERIOD = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [32*NUM_REQ-1:0]   req_period,
  output logic [NUM_REQ-1:0]      done,
  output logic                    aborted,
  output logic                    busy,
  output logic [OWNER_W-1:0]      owner,
  tmc_timer_sequencer_if.master   tmr
);

  localparam logic [OWNER_W:0] NUM_REQ_W     = (OWNER_W+1)'(NUM_REQ);
  localparam logic [31:0]      MIN_P         = 32'(MIN_PERIOD);
  localparam logic [2:0]       ADDR_STATUS   = 3'd0;
  localparam logic [2:0]       ADDR_CONTROL  = 3'd1;
  localparam logic [2:0]       ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0]       ADDR_PERIOD_H = 3'd3;
  localparam logic [15:0]      CTL_START_ITO = 16'h0005;
  localparam logic [15:0]      CTL_STOP      = 16'h0008;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_SETTLE, S_WR_CTL, S_WAIT, S_STOP, S_CLR, S_DONE
  } state_t;

  // The state register names the state whose registered outputs are on the
  // pins this cycle; the next-state logic computes the outputs of the state
  // being entered so that every output comes straight from a flop.
  state_t               state_reg, state_next;
  logic [OWNER_W-1:0]   owner_reg, owner_next;
  logic [OWNER_W-1:0]   ptr_reg, ptr_next;
  logic [15:0]          period_hi_reg, period_hi_next;
  logic                 abort_reg, abort_next;
  logic [NUM_REQ-1:0]   done_reg, done_next;
  logic                 aborted_reg, aborted_next;
  logic                 busy_reg, busy_next;
  logic [2:0]           addr_reg, addr_next;
  logic                 cs_reg, cs_next;
  logic                 wr_n_reg, wr_n_next;
  logic [15:0]          wdata_reg, wdata_next;

  logic [31:0]          period_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_period
    assign period_arr[gi] = req_period[32*gi +: 32];
  end

  // Round-robin scan: walk offsets from high to low so the lowest offset
  // from the pointer is the one left standing.
  logic [OWNER_W:0]     scan_idx;
  logic                 grant_valid;
  logic [OWNER_W-1:0]   grant_idx;
  logic [OWNER_W:0]     grant_inc;
  logic [31:0]          grant_period;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan_idx = {1'b0, ptr_reg} + (OWNER_W+1)'(i);
      if (scan_idx >= NUM_REQ_W) scan_idx = scan_idx - NUM_REQ_W;
      if (req[scan_idx[OWNER_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx[OWNER_W-1:0];
      end
    end
    grant_inc = {1'b0, grant_idx} + 1'b1;
    if (grant_inc >= NUM_REQ_W) grant_inc = '0;
    // Short periods are clamped up; large values load untouched.
    grant_period = (period_arr[grant_idx] < MIN_P) ? MIN_P : period_arr[grant_idx];
  end

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    ptr_next       = ptr_reg;
    period_hi_next = period_hi_reg;
    abort_next     = abort_reg;
    done_next      = '0;
    aborted_next   = 1'b0;
    busy_next      = busy_reg;
    addr_next      = ADDR_STATUS;
    cs_next        = 1'b0;
    wr_n_next      = 1'b1;
    wdata_next     = 16'h0000;

    case (state_reg)
      S_IDLE: begin
        // A pending irq here is not ours to clear; only a grant moves on.
        if (grant_valid) begin
          owner_next     = grant_idx;
          ptr_next       = grant_inc[OWNER_W-1:0];
          period_hi_next = grant_period[31:16];
          abort_next     = 1'b0;
          busy_next      = 1'b1;
          state_next     = S_WR_PL;
          addr_next      = ADDR_PERIOD_L;
          cs_next        = 1'b1;
          wr_n_next      = 1'b0;
          wdata_next     = grant_period[15:0];
        end
      end
      S_WR_PL: begin
        state_next = S_WR_PH;
        addr_next  = ADDR_PERIOD_H;
        cs_next    = 1'b1;
        wr_n_next  = 1'b0;
        wdata_next = period_hi_reg;
      end
      S_WR_PH: begin
        // Idle bus cycle lets the timer finish its reload before START.
        state_next = S_SETTLE;
      end
      S_SETTLE: begin
        state_next = S_WR_CTL;
        addr_next  = ADDR_CONTROL;
        cs_next    = 1'b1;
        wr_n_next  = 1'b0;
        wdata_next = CTL_START_ITO;
      end
      S_WR_CTL: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // irq has priority over a simultaneous withdrawal.
        if (tmr.tmr_irq) begin
          abort_next = 1'b0;
          state_next = S_CLR;
          addr_next  = ADDR_STATUS;
          cs_next    = 1'b1;
          wr_n_next  = 1'b0;
          wdata_next = 16'h0000;
        end else if (!req[owner_reg]) begin
          abort_next = 1'b1;
          state_next = S_STOP;
          addr_next  = ADDR_CONTROL;
          cs_next    = 1'b1;
          wr_n_next  = 1'b0;
          wdata_next = CTL_STOP;
        end
      end
      S_STOP: begin
        state_next = S_CLR;
        addr_next  = ADDR_STATUS;
        cs_next    = 1'b1;
        wr_n_next  = 1'b0;
        wdata_next = 16'h0000;
      end
      S_CLR: begin
        state_next             = S_DONE;
        done_next[owner_reg]   = 1'b1;
        aborted_next           = abort_reg;
      end
      S_DONE: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end
      default: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      owner_reg     <= '0;
      ptr_reg       <= '0;
      period_hi_reg <= 16'h0000;
      abort_reg     <= 1'b0;
      done_reg      <= '0;
      aborted_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      addr_reg      <= 3'd0;
      cs_reg        <= 1'b0;
      wr_n_reg      <= 1'b1;
      wdata_reg     <= 16'h0000;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      ptr_reg       <= ptr_next;
      period_hi_reg <= period_hi_next;
      abort_reg     <= abort_next;
      done_reg      <= done_next;
      aborted_reg   <= aborted_next;
      busy_reg      <= busy_next;
      addr_reg      <= addr_next;
      cs_reg        <= cs_next;
      wr_n_reg      <= wr_n_next;
      wdata_reg     <= wdata_next;
    end
  end

  assign done               = done_reg;
  assign aborted            = aborted_reg;
  assign busy               = busy_reg;
  assign owner              = owner_reg;
  assign tmr.tmr_address    = addr_reg;
  assign tmr.tmr_chipselect = cs_reg;
  assign tmr.tmr_write_n    = wr_n_reg;
  assign tmr.tmr_writedata  = wdata_reg;

endmodule
